// File: rtl/pc_stack_ctrl_pkg.sv
// Shared definitions for the PIC16F program-counter sequencer:
// op encodings, FSM states and the default address map.
package pc_stack_ctrl_pkg;
  localparam int PKG_PC_WIDTH   = 13;
  localparam int PKG_DEPTH_LOG2 = 3;
  localparam logic [PKG_PC_WIDTH-1:0] PKG_RESET_VECTOR = 13'h0000;
  localparam logic [PKG_PC_WIDTH-1:0] PKG_IRQ_VECTOR   = 13'h0004;

  typedef enum logic [2:0] {
    OP_NONE      = 3'd0,
    OP_GOTO      = 3'd1,
    OP_CALL      = 3'd2,
    OP_RETURN    = 3'd3,
    OP_RETFIE    = 3'd4,
    OP_SKIP      = 3'd5,
    OP_PCL_WRITE = 3'd6,
    OP_RSVD      = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;
endpackage

// File: rtl/pc_stack_ctrl_if.sv
// Decode-side control inputs and PC/status outputs of the sequencer.
interface pc_stack_ctrl_if;
  import pc_stack_ctrl_pkg::*;

  logic                      advance;
  op_e                       op;
  logic [10:0]               target;
  logic [4:0]                pclath;
  logic [7:0]                pcl_wdata;
  logic                      irq;
  logic                      gie;
  logic [PKG_PC_WIDTH-1:0]   pc;
  logic                      flush;
  logic                      gie_clr;
  logic                      gie_set;
  logic [PKG_DEPTH_LOG2:0]   depth;
  logic                      stack_ovf;
  logic                      stack_unf;

  modport master (
    output advance, op, target, pclath, pcl_wdata, irq, gie,
    input  pc, flush, gie_clr, gie_set, depth, stack_ovf, stack_unf
  );

  modport slave (
    input  advance, op, target, pclath, pcl_wdata, irq, gie,
    output pc, flush, gie_clr, gie_set, depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_stack_ctrl_hardware_stack.sv
// Circular return-address stack; a push when full silently overwrites the
// oldest entry, and top_o always shows the most recently pushed slot.
module hardware_stack #(
  parameter int WIDTH     = 13,
  parameter int TOS_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o
);
  localparam int DEPTH = 2 ** TOS_WIDTH;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [TOS_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
      ptr_q        <= ptr_q + TOS_WIDTH'(1);
    end else if (pop_i) begin
      ptr_q <= ptr_q - TOS_WIDTH'(1);
    end
  end

  assign top_o = mem_q[ptr_q - TOS_WIDTH'(1)];
endmodule

// File: rtl/pc_stack_ctrl.sv
// PIC16F fetch-PC sequencer: applies branch ops, interrupt entry or increment
// once per instruction cycle and drives the return stack.
module pc_stack_ctrl
  import pc_stack_ctrl_pkg::*;
#(
  parameter int                    PC_WIDTH     = PKG_PC_WIDTH,
  parameter int                    DEPTH_LOG2   = PKG_DEPTH_LOG2,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PKG_RESET_VECTOR,
  parameter logic [PC_WIDTH-1:0]   IRQ_VECTOR   = PKG_IRQ_VECTOR
) (
  input  logic           clk,
  input  logic           rst,
  pc_stack_ctrl_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] DEPTH_FULL = (DEPTH_LOG2+1)'(2 ** DEPTH_LOG2);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH_LOG2:0]   depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  gie_clr_q, gie_clr_d;
  logic                  gie_set_q, gie_set_d;
  logic                  push_req, pop_req;
  logic [PC_WIDTH-1:0]   stack_top;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   branch_tgt;
  logic [PC_WIDTH-1:0]   pcl_tgt;

  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign branch_tgt = {bus.pclath[4:3], bus.target};
  assign pcl_tgt    = {bus.pclath, bus.pcl_wdata};

  // The stack pointer only moves on a real pop so it stays aligned with depth.
  hardware_stack #(
    .WIDTH     (PC_WIDTH),
    .TOS_WIDTH (DEPTH_LOG2)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .pop_i       (pop_req && (depth_q != '0)),
    .push_data_i (pc_q),
    .top_o       (stack_top)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    gie_clr_d = 1'b0;
    gie_set_d = 1'b0;
    push_req  = 1'b0;
    pop_req   = 1'b0;

    if (bus.advance) begin
      if (state_q == ST_FLUSH) begin
        pc_d    = pc_inc;
        state_d = ST_RUN;
      end else begin
        unique case (bus.op)
          OP_GOTO: begin
            pc_d    = branch_tgt;
            state_d = ST_FLUSH;
          end
          OP_CALL: begin
            push_req = 1'b1;
            pc_d     = branch_tgt;
            state_d  = ST_FLUSH;
          end
          OP_RETURN, OP_RETFIE: begin
            pop_req   = 1'b1;
            pc_d      = stack_top;
            gie_set_d = (bus.op == OP_RETFIE);
            state_d   = ST_FLUSH;
          end
          OP_PCL_WRITE: begin
            pc_d    = pcl_tgt;
            state_d = ST_FLUSH;
          end
          OP_SKIP: begin
            pc_d    = pc_inc;
            state_d = ST_FLUSH;
          end
          default: begin
            if (bus.irq && bus.gie) begin
              push_req  = 1'b1;
              pc_d      = IRQ_VECTOR;
              gie_clr_d = 1'b1;
              state_d   = ST_FLUSH;
            end else begin
              pc_d = pc_inc;
            end
          end
        endcase
      end
    end

    // Depth saturates at full and floors at empty; both edges are sticky-flagged.
    if (push_req) begin
      if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
      else                       depth_d = depth_q + 1'b1;
    end
    if (pop_req) begin
      if (depth_q == '0) unf_d = 1'b1;
      else               depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      gie_clr_q <= 1'b0;
      gie_set_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      gie_clr_q <= gie_clr_d;
      gie_set_q <= gie_set_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flush     = (state_q == ST_FLUSH);
  assign bus.gie_clr   = gie_clr_q;
  assign bus.gie_set   = gie_set_q;
  assign bus.depth     = depth_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule
